// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data RAM; response wait_states+1 cycles after accept, req_ready only in IDLE.
// Stalls the pipeline until the response; define DMEM_RANGE_CHECK_EN to flag addresses beyond the RAM.
module dmem_responder #(
    parameter int word_width  = 32,
    parameter int depth_words = 1024,
    parameter int wait_states = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [word_width-1:0] req_addr,
    input  logic [word_width-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  rsp_valid,
    output logic [word_width-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  stall
);
    localparam int aw = $clog2(depth_words);
    localparam logic [3:0] last_cnt = (wait_states > 0) ? 4'(wait_states - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt;
    logic                  lat_write, lat_unsigned;
    logic [word_width-1:0] lat_addr, lat_wdata;
    logic [1:0]            lat_size;
    logic [word_width-1:0] mem [depth_words];

    logic                  cur_write, cur_unsigned;
    logic [word_width-1:0] cur_addr, cur_wdata;
    logic [1:0]            cur_size;
    logic [aw-1:0]         idx;
    logic                  accept, enter_resp, misalign, out_of_range, err;
    logic [3:0]            be;
    logic [word_width-1:0] wsh, rword, ld;
    logic [7:0]            bsel;
    logic [15:0]           hsel;

    // With zero wait states the RAM is accessed on the accept edge, before the latches load.
    assign cur_write    = (state == IDLE) ? req_write    : lat_write;
    assign cur_unsigned = (state == IDLE) ? req_unsigned : lat_unsigned;
    assign cur_addr     = (state == IDLE) ? req_addr     : lat_addr;
    assign cur_wdata    = (state == IDLE) ? req_wdata    : lat_wdata;
    assign cur_size     = (state == IDLE) ? req_size     : lat_size;
    assign idx          = cur_addr[aw+1:2];

    assign accept     = req_valid && (state == IDLE);
    assign enter_resp = reset && (state_nxt == RESP) && (state != RESP);
    assign req_ready  = (state == IDLE);
    assign stall      = accept || (state == WAIT) || ((state == RESP) && !rsp_valid);

    assign misalign = (cur_size == 2'b11) ||
                      ((cur_size == 2'b01) && cur_addr[0]) ||
                      ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00));
`ifdef DMEM_RANGE_CHECK_EN
    assign out_of_range = |cur_addr[word_width-1:aw+2];
`else
    assign out_of_range = 1'b0;
`endif
    assign err = misalign || out_of_range;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = (wait_states > 0) ? WAIT : RESP;
            WAIT:    if (cnt == last_cnt) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        be  = 4'b0000;
        wsh = cur_wdata;
        case (cur_size)
            2'b00: begin
                be  = 4'b0001 << cur_addr[1:0];
                wsh = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be  = cur_addr[1] ? 4'b1100 : 4'b0011;
                wsh = {2{cur_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        rword = mem[idx];
        bsel  = rword[{cur_addr[1:0], 3'b000} +: 8];
        hsel  = rword[{cur_addr[1], 4'b0000} +: 16];
        case (cur_size)
            2'b00:   ld = cur_unsigned ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
            2'b01:   ld = cur_unsigned ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
            default: ld = rword;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enter_resp && cur_write && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            lat_write    <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_size     <= 2'b00;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_error    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == WAIT) ? cnt + 4'd1 : 4'd0;
            if (accept) begin
                lat_write    <= req_write;
                lat_unsigned <= req_unsigned;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                lat_size     <= req_size;
            end
            rsp_valid <= enter_resp;
            rsp_error <= enter_resp && err;
            rsp_rdata <= (enter_resp && !err && !cur_write) ? ld : '0;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with one wait state, one with none; scoreboard-checked responses.
module tb_dmem_responder;
    localparam int WS = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_error, stall;
    logic [31:0] rsp_rdata;

    logic        v0, rdy0, w0, u0;
    logic [31:0] a0, wd0;
    logic [1:0]  sz0;
    logic        rv0, re0, st0;
    logic [31:0] rd0;

    dmem_responder #(.word_width(32), .depth_words(1024), .wait_states(WS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .stall(stall)
    );

    dmem_responder #(.word_width(32), .depth_words(1024), .wait_states(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(v0), .req_ready(rdy0), .req_write(w0),
        .req_addr(a0), .req_wdata(wd0), .req_size(sz0),
        .req_unsigned(u0), .rsp_valid(rv0), .rsp_rdata(rd0),
        .rsp_error(re0), .stall(st0)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t sb0[$];
    exp_t em, em0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: rsp_valid=1, expected no response");
            end else begin
                em = sb.pop_front();
                check("rsp_rdata", rsp_rdata, em.rdata);
                check("rsp_error", {31'b0, rsp_error}, {31'b0, em.err});
            end
        end
    end

    always @(negedge clk) begin
        if (rv0 === 1'b1) begin
            if (sb0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp0: rsp_valid=1, expected no response");
            end else begin
                em0 = sb0.pop_front();
                check("rsp_rdata0", rd0, em0.rdata);
                check("rsp_error0", {31'b0, re0}, {31'b0, em0.err});
            end
        end
    end

    task automatic acc(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic un,
                       input logic [31:0] er, input logic ee);
        int lat;
        int stl;
        bit got;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        req_size = sz; req_unsigned = un;
        sb.push_back('{rdata: er, err: ee});
        #1 stl = (stall === 1'b1) ? 1 : 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                lat = i;
                check("stall_in_rsp", {31'b0, stall}, 32'd0);
            end else if (stall === 1'b1) begin
                stl++;
            end
        end
        check("latency", lat, WS + 1);
        check("stall_cycles", stl, WS + 1);
    endtask

    task automatic acc0(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er);
        @(negedge clk);
        v0 = 1'b1; w0 = wr; a0 = a; wd0 = wd; sz0 = 2'b10; u0 = 1'b0;
        sb0.push_back('{rdata: er, err: 1'b0});
        @(posedge clk);
        #1 v0 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [4:0]  pv, pr;
    int          pulses;
    logic        rng_err;
    logic [31:0] word0;

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'b00; req_unsigned = 1'b0;
        v0 = 1'b0; w0 = 1'b0; a0 = '0; wd0 = '0; sz0 = 2'b00; u0 = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_error", {31'b0, rsp_error}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("reset_req_ready", {31'b0, req_ready}, 32'd1);
        check("reset_stall", {31'b0, stall}, 32'd0);

        // Zero-wait-state instance: preload, then back-to-back loads.
        acc0(1'b1, 32'h0, 32'hA5A5A5A5, 32'h0);
        acc0(1'b1, 32'h4, 32'h5A5A5A5A, 32'h0);
        @(negedge clk);
        v0 = 1'b1; w0 = 1'b0; a0 = 32'h0; sz0 = 2'b10; u0 = 1'b0;
        sb0.push_back('{rdata: 32'hA5A5A5A5, err: 1'b0});
        sb0.push_back('{rdata: 32'h5A5A5A5A, err: 1'b0});
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            pv[i] = rv0;
            pr[i] = rdy0;
            @(posedge clk);
            #1;
            if (i == 0) a0 = 32'h4;
            if (i == 2) v0 = 1'b0;
        end
        check("b2b_rsp_valid", {27'b0, pv}, 32'b01010);
        check("b2b_req_ready", {27'b0, pr}, 32'b10101);

        // Word, byte and half accesses around 0x20.
        acc(1'b1, 32'h20, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0);
        acc(1'b0, 32'h20, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
        acc(1'b1, 32'h20, 32'h0,        2'b10, 1'b0, 32'h0, 1'b0);
        acc(1'b1, 32'h21, 32'hFFFFFF80, 2'b00, 1'b0, 32'h0, 1'b0);
        acc(1'b0, 32'h20, 32'h0,        2'b10, 1'b0, 32'h00008000, 1'b0);
        acc(1'b0, 32'h21, 32'h0,        2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
        acc(1'b0, 32'h21, 32'h0,        2'b00, 1'b1, 32'h00000080, 1'b0);
        acc(1'b1, 32'h20, 32'h0,        2'b10, 1'b0, 32'h0, 1'b0);
        acc(1'b1, 32'h22, 32'h00001234, 2'b01, 1'b0, 32'h0, 1'b0);
        acc(1'b0, 32'h20, 32'h0,        2'b10, 1'b0, 32'h12340000, 1'b0);
        acc(1'b0, 32'h23, 32'h0,        2'b01, 1'b0, 32'h0, 1'b1);
        acc(1'b1, 32'h21, 32'hFFFFFFFF, 2'b01, 1'b0, 32'h0, 1'b1);
        acc(1'b1, 32'h20, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h0, 1'b1);
        acc(1'b1, 32'h22, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0, 1'b1);
        acc(1'b0, 32'h20, 32'h0,        2'b10, 1'b0, 32'h12340000, 1'b0);
        acc(1'b0, 32'h22, 32'h0,        2'b01, 1'b0, 32'h00001234, 1'b0);
        acc(1'b1, 32'h20, 32'h0000F00D, 2'b01, 1'b0, 32'h0, 1'b0);
        acc(1'b0, 32'h20, 32'h0,        2'b01, 1'b0, 32'hFFFFF00D, 1'b0);
        acc(1'b0, 32'h20, 32'h0,        2'b01, 1'b1, 32'h0000F00D, 1'b0);
        acc(1'b0, 32'h20, 32'h0,        2'b10, 1'b0, 32'h1234F00D, 1'b0);

        // Address beyond the RAM: wraps to word 0 or is rejected.
`ifdef DMEM_RANGE_CHECK_EN
        rng_err = 1'b1;
        word0   = 32'h0BADF00D;
`else
        rng_err = 1'b0;
        word0   = 32'hCAFEF00D;
`endif
        acc(1'b1, 32'h0,    32'h0BADF00D, 2'b10, 1'b0, 32'h0, 1'b0);
        acc(1'b1, 32'h1000, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0, rng_err);
        acc(1'b0, 32'h0,    32'h0,        2'b10, 1'b0, word0, 1'b0);

        // Reset in the middle of a store's wait state.
        acc(1'b1, 32'h10, 32'h11111111, 2'b10, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
        req_wdata = 32'h22222222; req_size = 2'b10; req_unsigned = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        reset = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) pulses++;
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) pulses++;
        end
        check("abort_no_rsp", pulses, 32'd0);
        acc(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h11111111, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        check("sb0_drained", sb0.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
